pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 36 +++
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard-control bundle.
// master: the pipeline datapath, which supplies hazard-compare and memory
// handshake signals and consumes the enables and flushes.
// slave: the hazard controller.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        idex_memread;
  logic [4:0]  idex_rt;
  logic        id_jump;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        mem_timeout;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output id_rs, id_rt, idex_memread, idex_rt, id_jump, ex_branch_taken,
           mem_req, mem_ready,
    input  pc_en, ifid_en, idex_en, ifid_flush, idex_flush, mem_timeout,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, idex_memread, idex_rt, id_jump, ex_branch_taken,
           mem_req, mem_ready,
    output pc_en, ifid_en, idex_en, ifid_flush, idex_flush, mem_timeout,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use bubbles, taken-branch
// and jump flushes, and a freeze while data memory is busy. A sticky flag
// reports a memory wait that reaches WAIT_MAX cycles.
// Optional build macro: HAZ_PERF_CNT_EN adds saturating 16-bit stall and
// flush performance counters; without it both counters read constant 0.
module pipe_hazard_ctrl #(
  parameter logic [7:0] WAIT_MAX = 8'd255
) (
  input logic             clk,
  input logic             rst,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN, LDUSE, MWAIT, FLUSH} state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL = ctrl_t'(5'b11100);
  localparam ctrl_t CTRL_FREEZE = ctrl_t'(5'b00000);
  localparam ctrl_t CTRL_BRANCH = ctrl_t'(5'b11111);
  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(5'b00101);
  localparam ctrl_t CTRL_IFKILL = ctrl_t'(5'b11110);

  state_t     state;
  state_t     state_nxt;
  ctrl_t      ctrl;
  logic [7:0] wait_cnt;
  logic [7:0] wait_inc;
  logic       timeout_q;
  logic       mem_wait;
  logic       load_use;

  assign mem_wait = hz.mem_req & ~hz.mem_ready;
  assign load_use = hz.idex_memread && (hz.idex_rt != 5'd0) &&
                    ((hz.idex_rt == hz.id_rs) || (hz.idex_rt == hz.id_rt));
  assign wait_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

  // Next state and control outputs, decoded from state and current inputs.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    ctrl      = CTRL_NORMAL;
    state_nxt = state;
    case (state)
      RUN, LDUSE: begin
        // LDUSE skips load-use: the ID/EX controls it would compare are a bubble.
        if (mem_wait) begin
          ctrl      = CTRL_FREEZE;
          state_nxt = MWAIT;
        end else if (hz.ex_branch_taken) begin
          ctrl      = CTRL_BRANCH;
          state_nxt = FLUSH;
        end else if ((state == RUN) && load_use) begin
          ctrl      = CTRL_BUBBLE;
          state_nxt = LDUSE;
        end else if (hz.id_jump) begin
          ctrl      = CTRL_IFKILL;
          state_nxt = RUN;
        end else begin
          state_nxt = RUN;
        end
      end
      MWAIT: begin
        if (mem_wait) begin
          ctrl = CTRL_FREEZE;
        end else begin
          state_nxt = RUN;
        end
      end
      FLUSH: begin
        if (mem_wait) begin
          ctrl      = CTRL_FREEZE;
          state_nxt = MWAIT;
        end else begin
          ctrl      = CTRL_IFKILL;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
    if (!rst) ctrl = CTRL_FREEZE;
  end

  assign hz.pc_en       = ctrl.pc_en;
  assign hz.ifid_en     = ctrl.ifid_en;
  assign hz.idex_en     = ctrl.idex_en;
  assign hz.ifid_flush  = ctrl.ifid_flush;
  assign hz.idex_flush  = ctrl.idex_flush;
  assign hz.mem_timeout = timeout_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state uses <= so all flops sample pre-edge values.
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  // Memory-wait counter, cleared outside MWAIT, and the sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else if (state == MWAIT) begin
      wait_cnt <= (state_nxt == MWAIT) ? wait_inc : 8'd0;
      if (wait_inc >= WAIT_MAX) timeout_q <= 1'b1;
    end else begin
      wait_cnt <= 8'd0;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  // Saturating counts of stalled cycles and cycles with any flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      if (!ctrl.pc_en && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if ((ctrl.ifid_flush || ctrl.idex_flush) && (flush_q != 16'hFFFF))
        flush_q <= flush_q + 16'd1;
    end
  end

  assign hz.stall_cnt = stall_q;
  assign hz.flush_cnt = flush_q;
`else
  assign hz.stall_cnt = 16'd0;
  assign hz.flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (WAIT_MAX=4). The driver applies one
// vector per cycle and queues its hand-computed response; the monitor pops
// and compares once per cycle, between the falling and rising edges.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl #(.WAIT_MAX(8'd4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  // {pc_en, ifid_en, idex_en, ifid_flush, idex_flush}
  localparam logic [4:0] Z = 5'b00000;  // reset
  localparam logic [4:0] N = 5'b11100;  // normal
  localparam logic [4:0] F = 5'b00000;  // memory freeze
  localparam logic [4:0] B = 5'b11111;  // taken branch
  localparam logic [4:0] L = 5'b00101;  // load-use bubble
  localparam logic [4:0] J = 5'b11110;  // jump / post-branch IF kill

  typedef struct {
    string       name;
    logic [4:0]  ctrl;
    logic        to;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_stall  = 16'd0;
  logic [15:0] m_flush  = 16'd0;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus plus the response expected while it is applied.
  task automatic step(input string name, input logic r,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic mr, input logic [4:0] xrt,
                      input logic j, input logic br,
                      input logic req, input logic rdy,
                      input logic [4:0] ectl, input logic eto);
    exp_t e;
    @(negedge clk);
    rst                = r;
    hz.id_rs           = rs;
    hz.id_rt           = rt;
    hz.idex_memread    = mr;
    hz.idex_rt         = xrt;
    hz.id_jump         = j;
    hz.ex_branch_taken = br;
    hz.mem_req         = req;
    hz.mem_ready       = rdy;
    e.name = name;
    e.ctrl = ectl;
    e.to   = eto;
`ifdef HAZ_PERF_CNT_EN
    if (!r) begin
      m_stall = 16'd0;
      m_flush = 16'd0;
    end
    e.stall = m_stall;
    e.flush = m_flush;
    if (r) begin
      if (!ectl[4] && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
      if ((ectl[1] || ectl[0]) && (m_flush != 16'hFFFF)) m_flush = m_flush + 16'd1;
    end
`else
    e.stall = 16'd0;
    e.flush = 16'd0;
`endif
    sb.push_back(e);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation each cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, " ctrl"},
              {11'd0, hz.pc_en, hz.ifid_en, hz.idex_en, hz.ifid_flush, hz.idex_flush},
              {11'd0, e.ctrl});
        check({e.name, " mem_timeout"}, {15'd0, hz.mem_timeout}, {15'd0, e.to});
        check({e.name, " stall_cnt"}, hz.stall_cnt, e.stall);
        check({e.name, " flush_cnt"}, hz.flush_cnt, e.flush);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    hz.id_rs = '0; hz.id_rt = '0; hz.idex_memread = 1'b0; hz.idex_rt = '0;
    hz.id_jump = 1'b0; hz.ex_branch_taken = 1'b0;
    hz.mem_req = 1'b0; hz.mem_ready = 1'b0;

    //     name            rst rs     rt     mr    xrt    j  br req rdy  ctrl to
    step("reset0",          0, 0,     0,     0,    0,     0, 0, 0, 0,   Z, 0);
    step("reset1",          0, 0,     0,     0,    0,     0, 0, 0, 0,   Z, 0);
    step("idle",            1, 0,     0,     0,    0,     0, 0, 0, 0,   N, 0);
    // load-use on rs, then masked cycle with undefined ID/EX controls
    step("lu_rs",           1, 2,     5,     1,    2,     0, 0, 0, 0,   L, 0);
    step("lu_rs_mask",      1, 5'bx,  5'bx,  1'bx, 5'bx,  0, 0, 0, 0,   N, 0);
    step("lu_rs_after",     1, 2,     5,     0,    2,     0, 0, 0, 0,   N, 0);
    // $0 never creates a hazard; rt match does; non-matching load does not
    step("rt0_no_stall",    1, 0,     0,     1,    0,     0, 0, 0, 0,   N, 0);
    step("lu_rt",           1, 3,     7,     1,    7,     0, 0, 0, 0,   L, 0);
    step("lu_rt_mask",      1, 5'bx,  5'bx,  1'bx, 5'bx,  0, 0, 0, 0,   N, 0);
    step("load_no_match",   1, 3,     6,     1,    7,     0, 0, 0, 0,   N, 0);
    // branch beats load-use; FLUSH masks hazard inputs and ignores jump
    step("br_vs_lu",        1, 4,     0,     1,    4,     0, 1, 0, 0,   B, 0);
    step("flush_cycle",     1, 5'bx,  5'bx,  1'bx, 5'bx,  1, 0, 0, 0,   J, 0);
    step("after_flush",     1, 0,     0,     0,    0,     0, 0, 0, 0,   N, 0);
    // jump, load-use over jump, branch taken while in LDUSE
    step("jump",            1, 0,     0,     0,    0,     1, 0, 0, 0,   J, 0);
    step("after_jump",      1, 0,     0,     0,    0,     0, 0, 0, 0,   N, 0);
    step("lu_vs_jump",      1, 1,     0,     1,    1,     1, 0, 0, 0,   L, 0);
    step("ldu_branch",      1, 5'bx,  5'bx,  1'bx, 5'bx,  0, 1, 0, 0,   B, 0);
    step("ldu_br_flush",    1, 5'bx,  5'bx,  1'bx, 5'bx,  0, 0, 0, 0,   J, 0);
    step("idle2",           1, 0,     0,     0,    0,     0, 0, 0, 0,   N, 0);
    // counters restart; 3 frozen cycles, mem wait beats branch
    step("rst_a",           0, 0,     0,     0,    0,     0, 0, 0, 0,   Z, 0);
    step("mw_vs_br",        1, 0,     0,     0,    0,     0, 1, 1, 0,   F, 0);
    step("mw_2",            1, 0,     0,     0,    0,     0, 0, 1, 0,   F, 0);
    step("mw_3",            1, 0,     0,     0,    0,     0, 0, 1, 0,   F, 0);
    step("mw_ready",        1, 0,     0,     0,    0,     0, 0, 1, 1,   N, 0);
    step("req_ready_run",   1, 0,     0,     0,    0,     0, 0, 1, 1,   N, 0);
    // mem wait takes precedence inside FLUSH
    step("br_b",            1, 0,     0,     0,    0,     0, 1, 0, 0,   B, 0);
    step("flush_mw",        1, 0,     0,     0,    0,     0, 0, 1, 0,   F, 0);
    step("flush_mw_done",   1, 0,     0,     0,    0,     0, 0, 1, 1,   N, 0);
    step("idle3",           1, 0,     0,     0,    0,     0, 0, 0, 0,   N, 0);
    // timeout: flag set at the end of the 4th MWAIT cycle, sticky until reset
    step("to_run",          1, 0,     0,     0,    0,     0, 0, 1, 0,   F, 0);
    step("to_m1",           1, 0,     0,     0,    0,     0, 0, 1, 0,   F, 0);
    step("to_m2",           1, 0,     0,     0,    0,     0, 0, 1, 0,   F, 0);
    step("to_m3",           1, 0,     0,     0,    0,     0, 0, 1, 0,   F, 0);
    step("to_m4",           1, 0,     0,     0,    0,     0, 0, 1, 0,   F, 0);
    step("to_m5",           1, 0,     0,     0,    0,     0, 0, 1, 0,   F, 1);
    step("to_ready",        1, 0,     0,     0,    0,     0, 0, 1, 1,   N, 1);
    step("to_sticky",       1, 0,     0,     0,    0,     0, 0, 0, 0,   N, 1);
    step("to_reset",        0, 0,     0,     0,    0,     0, 0, 0, 0,   Z, 0);
    step("to_cleared",      1, 0,     0,     0,    0,     0, 0, 0, 0,   N, 0);
    // reset mid-MWAIT and mid-FLUSH abandons the operation
    step("rmw_a",           1, 0,     0,     0,    0,     0, 0, 1, 0,   F, 0);
    step("rmw_b",           1, 0,     0,     0,    0,     0, 0, 1, 0,   F, 0);
    step("rmw_rst",         0, 0,     0,     0,    0,     0, 0, 1, 0,   Z, 0);
    step("rmw_post",        1, 0,     0,     0,    0,     0, 0, 0, 0,   N, 0);
    step("rfl_br",          1, 0,     0,     0,    0,     0, 1, 0, 0,   B, 0);
    step("rfl_rst",         0, 0,     0,     0,    0,     0, 0, 0, 0,   Z, 0);
    step("rfl_post",        1, 0,     0,     0,    0,     0, 0, 0, 0,   N, 0);
    step("rfl_post_lu",     1, 6,     0,     1,    6,     0, 0, 0, 0,   L, 0);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
